// File: rtl/div_pkg.sv
// Shared divide-count definitions: default width, run state and stop code.
// Used by the divide-ratio decoder and by every divide-count consumer.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam int unsigned DIV_STOP = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/div_halfcnt.sv
// Loadable half-period counter: counts 0..div_act-1 while run is high.
// Ports: clk, rst_n, run, clr, div_act in; bnd (last cycle of a half) out.
module div_halfcnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic [WIDTH-1:0] div_act,
    output logic             bnd
);

    logic [WIDTH-1:0] cnt;

    // div_act is never 0 while run is high, so div_act-1 cannot wrap.
    assign bnd = run && (cnt == div_act - WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !run || bnd) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/div_clkgen.sv
// 50%-duty divided clock and tick generator; count changes only at edges.
// Ports: clk, rst_n, En, Div in; Clk_out, Tick, Upd, Div_act out (registered).
module div_clkgen
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic [WIDTH-1:0] Div,
    output logic             Clk_out,
    output logic             Tick,
    output logic             Upd,
    output logic [WIDTH-1:0] Div_act
);

    state_t           state_q;
    state_t           state_d;
    logic             clk_d;
    logic             tick_d;
    logic             upd_d;
    logic [WIDTH-1:0] act_d;
    logic             go;
    logic             run;
    logic             start;
    logic             bnd;

    assign go    = En && (Div != WIDTH'(DIV_STOP));
    assign run   = (state_q == RUN);
    assign start = (state_q == IDLE) && go;

    div_halfcnt #(
        .WIDTH(WIDTH)
    ) u_halfcnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .clr    (start),
        .div_act(Div_act),
        .bnd    (bnd)
    );

    always_comb begin
        state_d = state_q;
        clk_d   = Clk_out;
        tick_d  = 1'b0;
        upd_d   = 1'b0;
        act_d   = Div_act;
        unique case (state_q)
            IDLE: begin
                clk_d = 1'b0;
                if (go) begin
                    act_d   = Div;
                    upd_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bnd) begin
                    if (!go) begin
                        // A low half that ends on stop simply stays low.
                        clk_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        clk_d  = ~Clk_out;
                        tick_d = ~Clk_out;
                        if (Div != Div_act) begin
                            act_d = Div;
                            upd_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            Clk_out <= 1'b0;
            Tick    <= 1'b0;
            Upd     <= 1'b0;
            Div_act <= '0;
        end else begin
            state_q <= state_d;
            Clk_out <= clk_d;
            Tick    <= tick_d;
            Upd     <= upd_d;
            Div_act <= act_d;
        end
    end

endmodule

// File: tb/tb_div_clkgen.sv
// Self-checking bench for div_clkgen: vector table, corner sequences,
// and randomized run against a boundary-time reference model.
module tb_div_clkgen;

    logic        clk;
    logic        rst_n;
    logic        En;
    logic [31:0] Div;
    logic        Clk_out;
    logic        Tick;
    logic        Upd;
    logic [31:0] Div_act;

    int total = 0;
    int bad   = 0;

    div_clkgen dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .En     (En),
        .Div    (Div),
        .Clk_out(Clk_out),
        .Tick   (Tick),
        .Upd    (Upd),
        .Div_act(Div_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [31:0] dv;
        logic        clk_e;
        logic        tick_e;
        logic        upd_e;
        logic [31:0] act_e;
    } vec_t;

    vec_t tbl[12];

    // Reference model: absolute edge number of the next half boundary.
    int          n;
    bit          m_run;
    bit          m_lvl;
    bit          m_tick;
    bit          m_upd;
    logic [31:0] m_len;
    int          m_next;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic model_init();
        n      = 0;
        m_run  = 0;
        m_lvl  = 0;
        m_tick = 0;
        m_upd  = 0;
        m_len  = 0;
        m_next = 0;
    endtask

    task automatic model_edge(input logic en, input logic [31:0] dv);
        n++;
        m_tick = 0;
        m_upd  = 0;
        if (!m_run) begin
            if (en && dv != 0) begin
                m_run  = 1;
                m_lvl  = 0;
                m_len  = dv;
                m_upd  = 1;
                m_next = n + int'(dv);
            end
        end else if (n == m_next) begin
            if (!en || dv == 0) begin
                m_run = 0;
                m_lvl = 0;
            end else begin
                m_lvl  = ~m_lvl;
                m_tick = m_lvl;
                if (dv != m_len) begin
                    m_len = dv;
                    m_upd = 1;
                end
                m_next = n + int'(m_len);
            end
        end
    endtask

    initial begin
        bit found;
        En    = 1'b1;
        Div   = 32'd3;
        rst_n = 1'b0;

        // Div=3 from reset: E0 is edge 1, rises at 4, 10; period 6.
        tbl[0]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 32'd3};
        tbl[1]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 32'd3};
        tbl[2]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 32'd3};
        tbl[3]  = '{1'b1, 32'd3, 1'b1, 1'b1, 1'b0, 32'd3};
        tbl[4]  = '{1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 32'd3};
        tbl[5]  = '{1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 32'd3};
        tbl[6]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 32'd3};
        tbl[7]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 32'd3};
        tbl[8]  = '{1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 32'd3};
        tbl[9]  = '{1'b1, 32'd3, 1'b1, 1'b1, 1'b0, 32'd3};
        tbl[10] = '{1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 32'd3};
        tbl[11] = '{1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 32'd3};

        #2;
        chk("rst_clk", {31'd0, Clk_out}, 32'd0);
        chk("rst_tick", {31'd0, Tick}, 32'd0);
        chk("rst_upd", {31'd0, Upd}, 32'd0);
        chk("rst_act", Div_act, 32'd0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            En  = tbl[i].en;
            Div = tbl[i].dv;
            step();
            chk($sformatf("tbl%0d_clk", i), {31'd0, Clk_out},
                {31'd0, tbl[i].clk_e});
            chk($sformatf("tbl%0d_tick", i), {31'd0, Tick},
                {31'd0, tbl[i].tick_e});
            chk($sformatf("tbl%0d_upd", i), {31'd0, Upd},
                {31'd0, tbl[i].upd_e});
            chk($sformatf("tbl%0d_act", i), Div_act, tbl[i].act_e);
        end

        // Div=1: toggles every cycle, tick every 2 cycles.
        En  = 1'b1;
        Div = 32'd1;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("d1_clk%0d", k), {31'd0, Clk_out},
                (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("d1_tick%0d", k), {31'd0, Tick},
                (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("d1_upd%0d", k), {31'd0, Upd},
                (k == 1) ? 32'd1 : 32'd0);
        end

        // Div 4 -> 2 mid high half: high k5..k8, low k9,k10, high k11,k12.
        En  = 1'b1;
        Div = 32'd4;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k >= 5) begin
                chk($sformatf("chg_clk%0d", k), {31'd0, Clk_out},
                    ((k >= 5 && k <= 8) || k == 11 || k == 12) ? 32'd1 : 32'd0);
            end
            if (k >= 6) begin
                chk($sformatf("chg_upd%0d", k), {31'd0, Upd},
                    (k == 9) ? 32'd1 : 32'd0);
            end
            if (k == 6) Div = 32'd2;
        end
        chk("chg_act", Div_act, 32'd2);

        // Div 5, drop En mid high half: high k6..k10 then low forever.
        En  = 1'b1;
        Div = 32'd5;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k >= 6) begin
                chk($sformatf("stop_clk%0d", k), {31'd0, Clk_out},
                    (k <= 10) ? 32'd1 : 32'd0);
            end
            if (k >= 7) begin
                chk($sformatf("stop_tick%0d", k), {31'd0, Tick}, 32'd0);
            end
            if (k == 7) En = 1'b0;
        end

        // Div=0 holds IDLE, then a large count starts the block.
        En  = 1'b1;
        Div = 32'd0;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("z_clk", {31'd0, Clk_out}, 32'd0);
            chk("z_tick", {31'd0, Tick}, 32'd0);
            chk("z_upd", {31'd0, Upd}, 32'd0);
            chk("z_act", Div_act, 32'd0);
        end
        Div = 32'h0BEB_C200;
        step();
        chk("big_upd", {31'd0, Upd}, 32'd1);
        chk("big_act", Div_act, 32'd200000000);
        chk("big_clk", {31'd0, Clk_out}, 32'd0);

        // Asynchronous reset mid-cycle while Clk_out is high.
        En  = 1'b1;
        Div = 32'd3;
        do_reset();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (Clk_out) found = 1;
        end
        chk("arst_wait", {31'd0, found}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_clk", {31'd0, Clk_out}, 32'd0);
        chk("arst_tick", {31'd0, Tick}, 32'd0);
        chk("arst_upd", {31'd0, Upd}, 32'd0);
        chk("arst_act", Div_act, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("arst_reupd", {31'd0, Upd}, 32'd1);
        chk("arst_react", Div_act, 32'd3);

        // Randomized run against the reference model.
        En  = 1'b1;
        Div = 32'd2;
        do_reset();
        model_init();
        for (int i = 0; i < 3000; i++) begin
            step();
            model_edge(En, Div);
            chk("rnd_clk", {31'd0, Clk_out}, {31'd0, m_lvl});
            chk("rnd_tick", {31'd0, Tick}, {31'd0, m_tick});
            chk("rnd_upd", {31'd0, Upd}, {31'd0, m_upd});
            if (m_run) chk("rnd_act", Div_act, m_len);
            if ($urandom_range(0, 5) == 0) begin
                Div = ($urandom_range(0, 9) == 0) ? 32'd0
                                                  : 32'($urandom_range(1, 6));
            end
            if ($urandom_range(0, 9) == 0) begin
                En = ($urandom_range(0, 3) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
